// File: rtl/and_share_arbiter_if.sv
// Request/response bundle between N requesters and the shared AND unit.
// Requester i owns bit i of req/gnt/ack and slice [i*WIDTH +: WIDTH] of a_in/b_in.
interface and_share_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   res;
  logic               res_valid;
  logic               busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, ack, res, res_valid, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, ack, res, res_valid, busy
  );
endinterface

// File: rtl/and_share_arbiter.sv
// Round-robin arbiter sharing one AND unit among N requesters; fixed
// three-cycle operation (grant, compute, respond).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for any req; winner and operands captured on exit
// S_BUSY | operands held, AND result registered on exit
// S_RESP | res_valid/ack strobe for one cycle; pointer advances on exit
module and_share_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_share_arbiter_if.slave   bus
);
  localparam int PW = (N > 2) ? $clog2(N) : 1;
  localparam logic [PW:0]   N_W  = (PW+1)'(N);
  localparam logic [PW-1:0] N_M1 = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [N-1:0]     gnt_q;
  logic [N-1:0]     ack_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             res_valid_q;
  logic             busy_q;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic             win_found_d;
  logic [PW-1:0]    win_off_d;
  logic [PW:0]      win_sum_d;
  logic [PW-1:0]    win_d;
  logic [N-1:0]     gnt_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [PW-1:0]    ptr_d;

  // Rotating the doubled request vector puts ptr at bit 0, so a plain
  // lowest-bit-first search gives the round-robin winner.
  assign req_dbl = {bus.req, bus.req} >> ptr_q;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    win_found_d = 1'b0;
    win_off_d   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found_d && req_rot[i]) begin
        win_found_d = 1'b1;
        win_off_d   = PW'(i);
      end
    end
  end

  assign win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
  assign win_d     = (win_sum_d >= N_W) ? PW'(win_sum_d - N_W) : win_sum_d[PW-1:0];
  assign gnt_d     = N'(1) << win_d;
  assign ptr_d     = (win_q == N_M1) ? '0 : win_q + PW'(1);

  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_d[i]) begin
        a_d = bus.a_in[i*WIDTH +: WIDTH];
        b_d = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            state_q <= S_BUSY;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          state_q     <= S_RESP;
          res_q       <= a_q & b_q;
          res_valid_q <= 1'b1;
          ack_q       <= gnt_q;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
          ack_q       <= '0;
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          ptr_q       <= ptr_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_and_share_arbiter.sv
// Self-checking bench for and_share_arbiter: directed scenarios plus random
// operations compared against a round-robin reference model.
module tb_and_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = 2*N + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  and_share_arbiter_if #(.N(N), .WIDTH(W)) bus();

  and_share_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ref_ptr = 0;
  logic [W-1:0]   last_res = '0;
  logic [N*W-1:0] a_v = '0;
  logic [N*W-1:0] b_v = '0;

  // Model: first requester set when scanning from ptr upward, modulo N.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_and(input int w);
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    a = a_v;
    b = b_v;
    return a[w*W +: W] & b[w*W +: W];
  endfunction

  function automatic logic [SW-1:0] status();
    return {bus.gnt, bus.ack, bus.res_valid, bus.busy};
  endfunction

  function automatic logic [SW-1:0] st(input logic [N-1:0] g, input logic [N-1:0] k,
                                        input logic v, input logic b);
    return {g, k, v, b};
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_v[i*W +: W] = a;
    b_v[i*W +: W] = b;
    bus.a_in = a_v;
    bus.b_in = b_v;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.ack)) begin
        failures++;
        $display("FAIL onehot gnt=%b ack=%b required at most one bit each", bus.gnt, bus.ack);
      end
    end
  end

  task automatic test_reset();
    logic [SW-1:0] e;
    bus.req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    e = st('0, '0, 1'b0, 1'b0);
    checks++;
    if (status() !== e) begin
      failures++; $display("FAIL reset_status got=%b exp=%b", status(), e);
    end
    checks++;
    if (bus.res !== '0) begin
      failures++; $display("FAIL reset_res got=%h exp=00", bus.res);
    end
    rst_n = 1'b1;
    ref_ptr = 0;
    last_res = '0;
  endtask

  task automatic test_single();
    logic [SW-1:0] e;
    @(negedge clk);
    set_op(2, 8'hF0, 8'h3C);
    bus.req = 4'b0100;
    @(negedge clk);
    e = st(4'b0100, '0, 1'b0, 1'b1);
    checks++;
    if (status() !== e) begin failures++; $display("FAIL single_grant got=%b exp=%b", status(), e); end
    @(negedge clk);
    e = st(4'b0100, 4'b0100, 1'b1, 1'b1);
    checks++;
    if (status() !== e) begin failures++; $display("FAIL single_resp got=%b exp=%b", status(), e); end
    checks++;
    if (bus.res !== 8'h30) begin failures++; $display("FAIL single_res got=%h exp=30", bus.res); end
    bus.req = '0;
    @(negedge clk);
    e = st('0, '0, 1'b0, 1'b0);
    checks++;
    if (status() !== e) begin failures++; $display("FAIL single_done got=%b exp=%b", status(), e); end
    ref_ptr = 3;
    last_res = 8'h30;
  endtask

  task automatic test_fairness();
    logic [SW-1:0] e;
    logic [W-1:0] er;
    logic [N-1:0] oh;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;
    rand_ops();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      er = model_and(k % N);
      oh = N'(1) << (k % N);
      @(negedge clk);
      e = st(oh, '0, 1'b0, 1'b1);
      checks++;
      if (status() !== e) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, status(), e); end
      rand_ops();
      @(negedge clk);
      e = st(oh, oh, 1'b1, 1'b1);
      checks++;
      if (status() !== e) begin failures++; $display("FAIL fair_resp%0d got=%b exp=%b", k, status(), e); end
      checks++;
      if (bus.res !== er) begin failures++; $display("FAIL fair_res%0d got=%h exp=%h", k, bus.res, er); end
      if (k == 4) bus.req = '0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL fair_idle%0d busy got=%b exp=0", k, bus.busy); end
      ref_ptr = (k % N + 1) % N;
      last_res = er;
    end
  endtask

  task automatic test_pointer_skip();
    logic [N-1:0] reqs [3];
    int wins [3];
    logic [SW-1:0] e;
    logic [N-1:0] oh;
    reqs[0] = 4'b0010; reqs[1] = 4'b0011; reqs[2] = 4'b0011;
    wins[0] = 1;       wins[1] = 0;       wins[2] = 1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      bus.req = reqs[k];
      oh = N'(1) << wins[k];
      @(negedge clk);
      checks++;
      if (bus.gnt !== oh) begin failures++; $display("FAIL skip_grant%0d got=%b exp=%b", k, bus.gnt, oh); end
      @(negedge clk);
      e = st(oh, oh, 1'b1, 1'b1);
      checks++;
      if (status() !== e) begin failures++; $display("FAIL skip_resp%0d got=%b exp=%b", k, status(), e); end
      last_res = model_and(wins[k]);
      checks++;
      if (bus.res !== last_res) begin failures++; $display("FAIL skip_res%0d got=%h exp=%h", k, bus.res, last_res); end
      bus.req = '0;
      @(negedge clk);
      ref_ptr = (wins[k] + 1) % N;
    end
  endtask

  task automatic test_mid_change();
    logic [SW-1:0] e;
    set_op(0, 8'hFF, 8'hAA);
    bus.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b exp=0001", bus.gnt); end
    bus.req = '0;
    set_op(0, 8'h00, 8'hAA);
    @(negedge clk);
    e = st(4'b0001, 4'b0001, 1'b1, 1'b1);
    checks++;
    if (status() !== e) begin failures++; $display("FAIL mid_resp got=%b exp=%b", status(), e); end
    checks++;
    if (bus.res !== 8'hAA) begin failures++; $display("FAIL mid_res got=%h exp=aa", bus.res); end
    @(negedge clk);
    ref_ptr = 1;
    last_res = 8'hAA;
  endtask

  task automatic test_reset_busy();
    logic [SW-1:0] e;
    rand_ops();
    bus.req = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstb_busy_before got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    e = st('0, '0, 1'b0, 1'b0);
    checks++;
    if (status() !== e) begin failures++; $display("FAIL rstb_immediate got=%b exp=%b", status(), e); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.ack !== '0) begin
        failures++; $display("FAIL rstb_no_pulse%0d got_valid=%b got_ack=%b exp 0", k, bus.res_valid, bus.ack);
      end
    end
    rst_n = 1'b1;
    ref_ptr = 0;
    last_res = '0;
    bus.req = 4'b1000;
    set_op(3, 8'h5A, 8'h0F);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL rstb_regrant got=%b exp=1000", bus.gnt); end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.res !== 8'h0A || bus.ack !== 4'b1000) begin
      failures++; $display("FAIL rstb_res got=%h/%b exp=0a/1000", bus.res, bus.ack);
    end
    @(negedge clk);
    ref_ptr = 0;
    last_res = 8'h0A;
  endtask

  task automatic test_idle_hold();
    logic [SW-1:0] e;
    bus.req = '0;
    rand_ops();
    e = st('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (status() !== e || bus.res !== last_res) begin
        failures++; $display("FAIL idle_hold%0d got=%b/%h exp=%b/%h", k, status(), bus.res, e, last_res);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] oh;
    logic [W-1:0] er;
    logic [SW-1:0] e;
    int w;
    for (int k = 0; k < 60; k++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      rand_ops();
      bus.req = r;
      w = pick(r, ref_ptr);
      if (w < 0) begin
        @(negedge clk);
        e = st('0, '0, 1'b0, 1'b0);
        checks++;
        if (status() !== e || bus.res !== last_res) begin
          failures++; $display("FAIL rnd_idle%0d got=%b/%h exp=%b/%h", k, status(), bus.res, e, last_res);
        end
      end else begin
        er = model_and(w);
        oh = N'(1) << w;
        @(negedge clk);
        e = st(oh, '0, 1'b0, 1'b1);
        checks++;
        if (status() !== e) begin failures++; $display("FAIL rnd_grant%0d got=%b exp=%b", k, status(), e); end
        bus.req = N'($urandom);
        rand_ops();
        @(negedge clk);
        e = st(oh, oh, 1'b1, 1'b1);
        checks++;
        if (status() !== e || bus.res !== er) begin
          failures++; $display("FAIL rnd_resp%0d got=%b/%h exp=%b/%h", k, status(), bus.res, e, er);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.res !== er) begin
          failures++; $display("FAIL rnd_done%0d busy=%b res=%h exp 0/%h", k, bus.busy, bus.res, er);
        end
        ref_ptr = (w + 1) % N;
        last_res = er;
      end
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_single();
    test_fairness();
    test_pointer_skip();
    test_mid_change();
    test_reset_busy();
    test_idle_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/and_share_arbiter.md
AND_SHARE_ARBITER -- requirements
Module: and_share_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters sharing one AND unit (legal range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N  per-requester level request; bit i = requester i.
REQ-006 a_in  input  N*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 b_in  input  N*WIDTH  operand B; same packing as a_in.
REQ-008 gnt  output  N  one-hot grant; registered.
REQ-009 ack  output  N  one-hot, one-cycle completion strobe to the served requester.
REQ-010 res  output  WIDTH  result a&b of the served requester; valid only while res_valid=1.
REQ-011 res_valid  output  1  one-cycle result strobe, coincident with ack.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL contain a three-state FSM: IDLE, BUSY, RESP.
REQ-014 IDLE -> BUSY on an edge where req != 0; IDLE SHALL be held while req == 0.
REQ-015 On the IDLE->BUSY edge, the block SHALL select the winner round-robin, set gnt to that one-hot bit, and latch the winner's a_in/b_in slices into internal registers.
REQ-016 Round-robin: search order SHALL start at the pointer ptr and proceed ptr, ptr+1, ... modulo N; the first set req bit wins.
REQ-017 BUSY -> RESP unconditionally after one cycle; res SHALL register the bitwise AND of the latched operands on this edge.
REQ-018 In RESP, res_valid=1, ack=gnt, and busy=1 for exactly one cycle; RESP -> IDLE unconditionally.
REQ-019 On the RESP->IDLE edge, gnt SHALL clear to 0 and ptr SHALL become (winner+1) mod N.
REQ-020 Latency SHALL be fixed: req sampled at edge t gives gnt high from t+1 and res_valid high from t+2 to t+3. Peak throughput is one operation per 3 cycles.
REQ-021 Operands and req SHALL be ignored outside the IDLE->BUSY edge. Changes or deassertion of req mid-operation SHALL NOT abort or alter the result.
REQ-022 A requester still asserting req in IDLE after its ack SHALL be re-arbitrated as a new operation at its rotated (lowest) priority.
REQ-023 Simultaneous requests: exactly one SHALL be granted per operation. No requester SHALL wait more than N-1 operations while continuously requesting.
REQ-024 res SHALL hold its last value when res_valid=0. gnt and ack SHALL never have more than one bit set.
REQ-025 Wrap-around: ptr SHALL wrap from N-1 to 0.

Reset
REQ-026 While rst_n=0, the block SHALL hold: state=IDLE, ptr=0, gnt=0, ack=0, res=0, res_valid=0, busy=0, operand registers=0. Assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-operation (BUSY or RESP) SHALL abandon the operation with no ack issued.
REQ-028 After rst_n deasserts, the first edge SHALL behave as IDLE with ptr=0.

Verification
REQ-029 Single request: req=4'b0100, a2=8'hF0, b2=8'h3C -> gnt=4'b0100 at t+1; res=8'h30, res_valid=1, ack=4'b0100 at t+2; busy low at t+3.
REQ-030 All-requesting fairness: req=4'b1111 held after reset -> grant order 0,1,2,3,0; each result equals that requester's a&b.
REQ-031 Pointer skip: after serving requester 1, req=4'b0011 -> requester 0 granted; then with req=4'b0011 still held, requester 1 is granted next.
REQ-032 Mid-operation change: req 4'b0001 with a0=8'hFF, b0=8'hAA; in BUSY, drop req and change a0=8'h00 -> res=8'hAA, ack=4'b0001.
REQ-033 Reset in BUSY: assert rst_n=0 -> gnt=0 and busy=0 immediately; no res_valid pulse; after release, req=4'b1000 with ptr=0 is granted normally.
REQ-034 Idle hold: req=0 for 20 cycles -> busy, gnt, ack, res_valid stay 0; res unchanged.
